// File: rtl/mulaw_pkg.sv
// Shared types and helpers for the mu-law codec support blocks.
//   rt_state_t : run state of the round-trip checker (IDLE, RUN, DONE)
//   abs_sat    : saturating absolute value of a w-bit two's complement value
//                carried in the low w bits of a 64-bit word (1 <= w <= 64)
package mulaw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rt_state_t;

  // The most negative w-bit value has no positive counterpart, so it
  // saturates to 2^(w-1)-1 instead of wrapping back to itself.
  function automatic logic [63:0] abs_sat(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    logic [63:0] x;
    logic [63:0] mneg;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    x    = v & mask;
    mneg = 64'd1 << (w - 1);
    if (x == mneg)
      return mneg - 64'd1;
    else if ((x & mneg) != 64'd0)
      return ((~x) + 64'd1) & mask;
    else
      return x;
  endfunction

endpackage

// File: rtl/mulaw_rt_fifo.sv
// Single-clock reference FIFO for the round-trip checker.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_flush           : empties the FIFO (pointers and count to zero)
//   i_push, i_din     : write request and data; dropped when full unless
//                       a pop happens in the same cycle
//   i_pop             : read request; o_dout is the current head
//   o_full, o_empty   : occupancy flags
//   o_count           : occupancy, 0..P_DEPTH
module mulaw_rt_fifo #(
  parameter int DATA_W  = 16,
  parameter int P_DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [DATA_W-1:0]          i_din,
  output logic [DATA_W-1:0]          o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(P_DEPTH):0]   o_count
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [P_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign o_full  = (o_count == CW'(P_DEPTH));
  assign o_empty = (o_count == '0);
  assign o_dout  = mem[rd_ptr];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = i_push && !i_flush && (!o_full || i_pop);
  assign rd_en = i_pop && !i_flush && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else if (i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   o_count <= o_count + CW'(1);
        2'b01:   o_count <= o_count - CW'(1);
        default: o_count <= o_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_din;
  end

endmodule

// File: rtl/mulaw_rt_checker.sv
// Round-trip checker for the mu-law enc->dec chain. Samples entering the
// encoder are queued; each decoder output pops the oldest queued sample and
// the signed error dut - ref is checked against a tolerance.
//   i_clk, i_rst               : clock, asynchronous active-high reset
//   i_start                    : begin a run from IDLE or DONE (ignored in RUN)
//   i_tol                      : max allowed |error|, latched at start
//   i_ref_dt, i_ref_enable     : reference sample into the queue
//   i_dut_dt, i_dut_enable     : decoder sample, compared with queue head
//   o_delta, o_delta_valid     : last error and its update strobe
//   o_err_cnt, o_cmp_cnt       : failing / compared pair counts (saturating)
//   o_max_abs                  : largest |error| this run
//   o_ovf, o_unf               : sticky queue overflow / underflow
//   o_done, o_pass             : run finished and its verdict
module mulaw_rt_checker
  import mulaw_pkg::*;
#(
  parameter int          DATA_W        = 16,
  parameter int          P_FIFO_DEPTH  = 16,
  parameter int unsigned P_NUM_SAMPLES = 32'd65536
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tol,
  input  logic [DATA_W-1:0] i_ref_dt,
  input  logic              i_ref_enable,
  input  logic [DATA_W-1:0] i_dut_dt,
  input  logic              i_dut_enable,
  output logic [DATA_W-1:0] o_delta,
  output logic              o_delta_valid,
  output logic [31:0]       o_err_cnt,
  output logic [DATA_W-1:0] o_max_abs,
  output logic [31:0]       o_cmp_cnt,
  output logic              o_ovf,
  output logic              o_unf,
  output logic              o_done,
  output logic              o_pass
);

  localparam int CW = $clog2(P_FIFO_DEPTH) + 1;

  rt_state_t state;
  rt_state_t state_next;

  logic              start_evt;
  logic              push_req;
  logic              pop_req;
  logic              pop_ok;
  logic              ovf_evt;
  logic              unf_evt;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] tol_lat;

  logic [DATA_W-1:0] head_p0;
  logic [DATA_W-1:0] dut_p0;
  logic              vld_p0;

  logic signed [DATA_W-1:0] delta_s;
  logic [DATA_W-1:0]        abs_s;
  logic                     cmp_upd;

  logic [31:0]       cmp_next;
  logic [31:0]       err_next;
  logic [DATA_W-1:0] max_next;
  logic              ovf_next;
  logic              unf_next;

  // Enables are only honoured in RUN, so a push/pop on the start edge is lost.
  assign start_evt = i_start && (state != RUN);
  assign push_req  = (state == RUN) && i_ref_enable;
  assign pop_req   = (state == RUN) && i_dut_enable;
  assign pop_ok    = pop_req && (fifo_count != '0);
  assign ovf_evt   = push_req && fifo_full && !pop_req;
  assign unf_evt   = pop_req && fifo_empty;

  mulaw_rt_fifo #(
    .DATA_W  (DATA_W),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (start_evt),
    .i_push  (push_req),
    .i_pop   (pop_ok),
    .i_din   (i_ref_dt),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // ---- stage p0: capture popped head and decoder sample ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) vld_p0 <= 1'b0;
    else       vld_p0 <= pop_ok;
  end

  always_ff @(posedge i_clk) begin
    if (pop_ok) begin
      head_p0 <= fifo_dout;
      dut_p0  <= i_dut_dt;
    end
  end

  // ---- stage p1: error, magnitude, statistics ----
  assign delta_s = $signed(dut_p0 - head_p0);
  assign abs_s   = DATA_W'(abs_sat(64'(delta_s), DATA_W));
  assign cmp_upd = vld_p0 && (state == RUN);

  always_comb begin
    state_next = state;
    cmp_next   = o_cmp_cnt;
    err_next   = o_err_cnt;
    max_next   = o_max_abs;
    ovf_next   = o_ovf;
    unf_next   = o_unf;
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          state_next = RUN;
          cmp_next   = '0;
          err_next   = '0;
          max_next   = '0;
          ovf_next   = 1'b0;
          unf_next   = 1'b0;
        end
      end
      RUN: begin
        if (cmp_upd) begin
          if (o_cmp_cnt != '1) cmp_next = o_cmp_cnt + 32'd1;
          if ((abs_s > tol_lat) && (o_err_cnt != '1)) err_next = o_err_cnt + 32'd1;
          if (abs_s > o_max_abs) max_next = abs_s;
        end
        if (ovf_evt) ovf_next = 1'b1;
        if (unf_evt) unf_next = 1'b1;
        if (ovf_next || unf_next || (cmp_next == P_NUM_SAMPLES)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tol_lat       <= '0;
      o_delta       <= '0;
      o_delta_valid <= 1'b0;
      o_err_cnt     <= '0;
      o_max_abs     <= '0;
      o_cmp_cnt     <= '0;
      o_ovf         <= 1'b0;
      o_unf         <= 1'b0;
      o_done        <= 1'b0;
      o_pass        <= 1'b0;
    end else begin
      if (start_evt) tol_lat <= i_tol;
      if (cmp_upd)   o_delta <= delta_s;
      o_delta_valid <= cmp_upd;
      o_err_cnt     <= err_next;
      o_max_abs     <= max_next;
      o_cmp_cnt     <= cmp_next;
      o_ovf         <= ovf_next;
      o_unf         <= unf_next;
      o_done        <= (state_next == DONE);
      o_pass        <= (state_next == DONE) && (err_next == '0) && !ovf_next && !unf_next;
    end
  end

endmodule

// File: tb/tb_mulaw_rt_checker.sv
// Directed bench for mulaw_rt_checker (16-bit samples, depth 16, 56-pair runs).
module tb_mulaw_rt_checker;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] tol = '0;
  logic [DW-1:0] ref_dt = '0;
  logic          ref_en = 1'b0;
  logic [DW-1:0] dut_dt = '0;
  logic          dut_en = 1'b0;

  logic [DW-1:0] delta;
  logic          delta_valid;
  logic [31:0]   err_cnt;
  logic [DW-1:0] max_abs;
  logic [31:0]   cmp_cnt;
  logic          ovf;
  logic          unf;
  logic          done;
  logic          pass;

  int n_asrt = 0;
  int n_fail = 0;

  mulaw_rt_checker #(
    .DATA_W        (DW),
    .P_FIFO_DEPTH  (16),
    .P_NUM_SAMPLES (32'd56)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_tol         (tol),
    .i_ref_dt      (ref_dt),
    .i_ref_enable  (ref_en),
    .i_dut_dt      (dut_dt),
    .i_dut_enable  (dut_en),
    .o_delta       (delta),
    .o_delta_valid (delta_valid),
    .o_err_cnt     (err_cnt),
    .o_max_abs     (max_abs),
    .o_cmp_cnt     (cmp_cnt),
    .o_ovf         (ovf),
    .o_unf         (unf),
    .o_done        (done),
    .o_pass        (pass)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [DW-1:0] t);
    tol   = t;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Push one reference, pop it one cycle later, wait for the compare result.
  task automatic pair(input logic [DW-1:0] r, input logic [DW-1:0] d);
    ref_dt = r; ref_en = 1'b1;
    step();
    ref_en = 1'b0;
    dut_dt = d; dut_en = 1'b1;
    step();
    dut_en = 1'b0;
    step();
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_delta"},   32'(delta),       32'h0);
    chk({pfx, "_dvalid"},  32'(delta_valid), 32'h0);
    chk({pfx, "_err"},     err_cnt,          32'h0);
    chk({pfx, "_max"},     32'(max_abs),     32'h0);
    chk({pfx, "_cmp"},     cmp_cnt,          32'h0);
    chk({pfx, "_ovf"},     32'(ovf),         32'h0);
    chk({pfx, "_unf"},     32'(unf),         32'h0);
    chk({pfx, "_done"},    32'(done),        32'h0);
    chk({pfx, "_pass"},    32'(pass),        32'h0);
  endtask

  function automatic logic [DW-1:0] seqv(input int k);
    return 16'h1000 + DW'(k * 3);
  endfunction

  initial begin
    // Reset state
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_all_zero("reset");

    // Tolerance boundary: |3| == tol 3 passes, then empty pop underflows
    do_start(16'd3);
    ref_dt = 16'h0100; ref_en = 1'b1;
    step();
    ref_en = 1'b0;
    step();
    dut_dt = 16'h0103; dut_en = 1'b1;
    step();
    dut_en = 1'b0;
    chk("lat_not_yet", 32'(delta_valid), 32'h0);
    step();
    chk("t3_delta",  32'(delta),       32'h0003);
    chk("t3_dvalid", 32'(delta_valid), 32'h1);
    chk("t3_err",    err_cnt,          32'd0);
    chk("t3_max",    32'(max_abs),     32'h0003);
    chk("t3_cmp",    cmp_cnt,          32'd1);
    dut_en = 1'b1;
    step();
    dut_en = 1'b0;
    chk("unf_flag", 32'(unf),  32'h1);
    chk("unf_done", 32'(done), 32'h1);
    chk("unf_pass", 32'(pass), 32'h0);
    chk("unf_cmp",  cmp_cnt,   32'd1);

    // tol 2: same pair fails; signed wrap; most-negative saturation
    do_start(16'd2);
    chk("restart_cmp",  cmp_cnt,      32'd0);
    chk("restart_unf",  32'(unf),     32'h0);
    chk("restart_done", 32'(done),    32'h0);
    pair(16'h0100, 16'h0103);
    chk("t2_err", err_cnt,      32'd1);
    chk("t2_max", 32'(max_abs), 32'h0003);
    pair(16'h7FFF, 16'h8000);
    chk("wrap_delta", 32'(delta),   32'h0001);
    chk("wrap_err",   err_cnt,      32'd1);
    chk("wrap_max",   32'(max_abs), 32'h0003);
    pair(16'h0000, 16'h8000);
    chk("sat_delta", 32'(delta),   32'h8000);
    chk("sat_max",   32'(max_abs), 32'h7FFF);
    chk("sat_err",   err_cnt,      32'd2);
    chk("sat_cmp",   cmp_cnt,      32'd3);

    // Overflow: 17 pushes, no pops
    for (int i = 0; i < 16; i++) begin
      ref_dt = DW'(i); ref_en = 1'b1;
      step();
    end
    chk("full_no_ovf",  32'(ovf),  32'h0);
    chk("full_no_done", 32'(done), 32'h0);
    step();
    ref_en = 1'b0;
    chk("ovf_flag", 32'(ovf),  32'h1);
    chk("ovf_done", 32'(done), 32'h1);
    chk("ovf_pass", 32'(pass), 32'h0);

    // Full FIFO with sustained push+pop across pointer wrap; push on the
    // start edge must be discarded or every later compare is misaligned.
    ref_dt = 16'hDEAD; ref_en = 1'b1;
    do_start(16'd0);
    for (int i = 0; i < 16; i++) begin
      ref_dt = seqv(i); ref_en = 1'b1;
      step();
    end
    for (int i = 0; i < 40; i++) begin
      ref_dt = seqv(16 + i); ref_en = 1'b1;
      dut_dt = seqv(i);      dut_en = 1'b1;
      step();
    end
    ref_en = 1'b0;
    chk("wrap_ovf",     32'(ovf),         32'h0);
    chk("wrap_dvalid",  32'(delta_valid), 32'h1);
    chk("wrap_err40",   err_cnt,          32'd0);
    for (int i = 0; i < 16; i++) begin
      dut_dt = seqv(40 + i); dut_en = 1'b1;
      step();
    end
    dut_en = 1'b0;
    chk("drain_cmp55",  cmp_cnt,   32'd55);
    chk("drain_undone", 32'(done), 32'h0);
    step();
    chk("run_cmp",  cmp_cnt,      32'd56);
    chk("run_done", 32'(done),    32'h1);
    chk("run_pass", 32'(pass),    32'h1);
    chk("run_err",  err_cnt,      32'd0);
    chk("run_max",  32'(max_abs), 32'h0);
    chk("run_ovf",  32'(ovf),     32'h0);
    chk("run_unf",  32'(unf),     32'h0);
    step();
    chk("done_hold", 32'(done), 32'h1);

    // Reset mid-run after 10 failing compares, then a clean restart
    do_start(16'd0);
    for (int i = 0; i < 10; i++) pair(DW'(16'h0200 + i), DW'(16'h0201 + i));
    chk("pre_rst_cmp", cmp_cnt, 32'd10);
    chk("pre_rst_err", err_cnt, 32'd10);
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    rst = 1'b0;
    step();
    do_start(16'd0);
    pair(16'h0055, 16'h0055);
    chk("post_cmp",   cmp_cnt,     32'd1);
    chk("post_err",   err_cnt,     32'd0);
    chk("post_delta", 32'(delta),  32'h0);
    chk("post_done",  32'(done),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
